reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
//   Write-side driver for the 16x16 register file. Collects results from the ALU and memory
//   paths, buffers one result per source, arbitrates them onto the regfile's single write port
//   (wen/selRd/rd), and keeps a per-register pending-write scoreboard that decode queries to stall.
//   Sits between the execute/memory stages and regfile; decode issues claims, writeback commits them.
// PARAMETERS
//   DATA_W   16  width of result data / regfile rd port
//   SEL_W    4   register select width
//   REG_CNT  16  number of architectural registers (2**SEL_W)
// PORTS
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous, active-high reset
//   alu_valid    in   1       ALU result offered this cycle
//   alu_sel      in   SEL_W   ALU destination register
//   alu_data     in   DATA_W  ALU result
//   alu_ready    out  1       ALU slot can accept this cycle
//   mem_valid    in   1       memory load result offered
//   mem_sel      in   SEL_W   load destination register
//   mem_data     in   DATA_W  load result
//   mem_ready    out  1       memory slot can accept
//   wen          out  1       regfile write enable (to regfile wen)
//   selRd        out  SEL_W   regfile write select (to regfile selRd)
//   rd           out  DATA_W  regfile write data (to regfile rd)
//   claim_valid  in   1       decode issued an instruction writing claim_sel
//   claim_sel    in   SEL_W   register being claimed
//   selRs        in   SEL_W   decode source-1 select (shared with regfile selRs)
//   selRt        in   SEL_W   decode source-2 select (shared with regfile selRt)
//   rs_busy      out  1       busy[selRs], combinational from registered scoreboard
//   rt_busy      out  1       busy[selRt]
// BEHAVIOUR
//   Reset (async, immediate): both slots empty, busy[*]=0, rr_ptr=MEM; hence wen=0, selRd=0, rd=0,
//     alu_ready=mem_ready=1, rs_busy=rt_busy=0. Reset mid-operation drops held results silently.
//   Slot: one holding reg per source {held, sel, data}. Transfer = valid & ready at rising edge.
//     ready = ~held | granted (grant frees the slot same cycle -> one result/cycle back-to-back).
//   Arbitration (comb, from held bits only, no path from *_valid):
//     one slot held -> grant it; both held -> grant side != rr_ptr-last, i.e. round-robin;
//     rr_ptr updates only on contended cycles; after reset MEM wins first contention.
//   Write port: wen = any grant; selRd/rd = granted slot's sel/data; all zero when wen=0.
//     Latency: result accepted at edge k is on wen/selRd/rd during cycle k, written at edge k+1.
//     Minimum 1 cycle accept->commit; worst case 2 when contended. Max throughput 1 write/cycle.
//   Scoreboard busy[REG_CNT]: set on claim_valid for claim_sel; clear at edge where wen=1 for selRd.
//     Same reg claimed and committed same edge -> set wins (new writer outstanding).
//     Claim of already-busy reg -> stays busy (no counting; decode never issues two writers).
//     rs_busy/rt_busy read registered busy; no bypass of the committing write.
//   No special case for register 0; selRd passed unchanged. Widths exact, no truncation.
// STRUCTURE
//   Shared package: DATA_W/SEL_W/REG_CNT constants, SRC_ALU=0/SRC_MEM=1 source encoding.
//   Sub-module wb_slot (instantiated x2): one-entry holding register with valid/ready/take.
//   Top holds arbiter, rr_ptr, output mux and scoreboard.
// TESTING
//   1 reset: rst=1 mid-run with both slots held -> wen=0, both ready=1, busy all 0 immediately.
//   2 single ALU: claim r3, then alu_valid sel=3 data=16'h00A5 at edge k -> cycle k wen=1,
//     selRd=3, rd=00A5; rs_busy(selRs=3)=1 until edge k+1, then 0; regfile r3=00A5.
//   3 contention: alu(r1,1111) and mem(r2,2222) same edge -> mem written first, alu next cycle,
//     alu_ready=0 for exactly one cycle; next contention grants ALU first.
//   4 streaming: alu_valid held 8 cycles sel=0..7 data=sel -> wen=1 every cycle, r0..r7=0..7.
//   5 claim/commit collision: r5 committing while claim_sel=5 same edge -> busy[5]=1 after edge.
//   6 dual query: selRs=2, selRt=9 with only r9 claimed -> rs_busy=0, rt_busy=1.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register-file writeback block.
//   DATA_W  : width of result data and of the regfile write-data port
//   SEL_W   : register select width
//   REG_CNT : number of architectural registers (2**SEL_W)
//   src_e   : result source encoding, used by the round-robin pointer
package reg_writeback_pkg;

    localparam int DATA_W  = 16;
    localparam int SEL_W   = 4;
    localparam int REG_CNT = 2 ** SEL_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // Returns the source that did not just win, so that contended cycles alternate
    function automatic src_e otherSrc(input src_e s);
        return (s == SRC_MEM) ? SRC_ALU : SRC_MEM;
    endfunction

endpackage

// File: rtl/reg_writeback_wb_slot.sv
// One-entry holding register for a single result source.
// Ports:
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   valid_i   : producer offers a result this cycle
//   sel_i     : destination register of the offered result
//   data_i    : offered result data
//   take_i    : the arbiter is writing the held entry this cycle
//   ready_o   : slot can accept a result this cycle
//   held_o    : slot holds a result
//   sel_o     : held destination register
//   data_o    : held result data
module wb_slot
    import reg_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              take_i,
    output logic              ready_o,
    output logic              held_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic [DATA_W-1:0] data_o
);

    logic              held_q, held_d;
    logic [SEL_W-1:0]  sel_q,  sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load;

    // A granted entry leaves at the same edge a new one can arrive, which is
    // what lets a source stream one result per cycle.
    assign ready_o = ~held_q | take_i;
    assign load    = valid_i & ready_o;

    always_comb begin
        held_d = held_q;
        sel_d  = sel_q;
        data_d = data_q;
        if (load) begin
            held_d = 1'b1;
            sel_d  = sel_i;
            data_d = data_i;
        end else if (take_i) begin
            held_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            held_q <= held_d;
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

    assign held_o = held_q;
    assign sel_o  = sel_q;
    assign data_o = data_q;

endmodule

// File: rtl/reg_writeback.sv
// Write-side driver for the 16x16 register file.
// Buffers one ALU and one memory result, arbitrates them round-robin onto the
// regfile's single write port and tracks a per-register pending-write scoreboard
// that decode queries for stalls.
// Ports:
//   clk, rst                         : clock and asynchronous active-high reset
//   alu_valid/alu_sel/alu_data/alu_ready : ALU result handshake
//   mem_valid/mem_sel/mem_data/mem_ready : memory load result handshake
//   wen/selRd/rd                     : regfile write port
//   claim_valid/claim_sel            : decode marks a register as having a writer in flight
//   selRs/selRt                      : decode source selects
//   rs_busy/rt_busy                  : pending-write status of the source registers
module reg_writeback
    import reg_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              wen,
    output logic [SEL_W-1:0]  selRd,
    output logic [DATA_W-1:0] rd,
    input  logic              claim_valid,
    input  logic [SEL_W-1:0]  claim_sel,
    input  logic [SEL_W-1:0]  selRs,
    input  logic [SEL_W-1:0]  selRt,
    output logic              rs_busy,
    output logic              rt_busy
);

    logic              aluHeld, memHeld;
    logic [SEL_W-1:0]  aluSelQ, memSelQ;
    logic [DATA_W-1:0] aluDataQ, memDataQ;
    logic              grantAlu, grantMem;

    src_e              rrPtr_q, rrPtr_d;
    logic [REG_CNT-1:0] busy_q, busy_d;

    wb_slot u_aluSlot (
        .clk     (clk),
        .rst     (rst),
        .valid_i (alu_valid),
        .sel_i   (alu_sel),
        .data_i  (alu_data),
        .take_i  (grantAlu),
        .ready_o (alu_ready),
        .held_o  (aluHeld),
        .sel_o   (aluSelQ),
        .data_o  (aluDataQ)
    );

    wb_slot u_memSlot (
        .clk     (clk),
        .rst     (rst),
        .valid_i (mem_valid),
        .sel_i   (mem_sel),
        .data_i  (mem_data),
        .take_i  (grantMem),
        .ready_o (mem_ready),
        .held_o  (memHeld),
        .sel_o   (memSelQ),
        .data_o  (memDataQ)
    );

    // Arbitration looks only at the held bits, so there is no combinational
    // path from a producer's valid to the other producer's ready. rrPtr_q names
    // the side that wins the next contended cycle and flips only when both
    // slots compete.
    always_comb begin
        grantAlu = 1'b0;
        grantMem = 1'b0;
        rrPtr_d  = rrPtr_q;
        if (aluHeld && memHeld) begin
            if (rrPtr_q == SRC_MEM) begin
                grantMem = 1'b1;
            end else begin
                grantAlu = 1'b1;
            end
            rrPtr_d = otherSrc(rrPtr_q);
        end else if (aluHeld) begin
            grantAlu = 1'b1;
        end else if (memHeld) begin
            grantMem = 1'b1;
        end
    end

    // Write port is forced to zero when idle so the regfile never sees stale data.
    always_comb begin
        wen   = 1'b0;
        selRd = '0;
        rd    = '0;
        if (grantMem) begin
            wen   = 1'b1;
            selRd = memSelQ;
            rd    = memDataQ;
        end else if (grantAlu) begin
            wen   = 1'b1;
            selRd = aluSelQ;
            rd    = aluDataQ;
        end
    end

    // The claim is applied after the commit clear so that a new writer issued
    // at the same edge as the old one commits stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (wen) begin
            busy_d[selRd] = 1'b0;
        end
        if (claim_valid) begin
            busy_d[claim_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr_q <= SRC_MEM;
            busy_q  <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
            busy_q  <= busy_d;
        end
    end

    // Decode sees the registered scoreboard only; a commit in flight still reads busy.
    assign rs_busy = busy_q[selRs];
    assign rt_busy = busy_q[selRt];

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a table of per-cycle vectors plus
// hand-written sequences for streaming and mid-run reset.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, claim_valid;
    logic [3:0]  alu_sel, mem_sel, claim_sel, selRs, selRt;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, wen, rs_busy, rt_busy;
    logic [3:0]  selRd;
    logic [15:0] rd;

    int checks = 0;
    int passes = 0;

    logic [15:0] tbRegs [16];

    typedef struct {
        logic        av;
        logic [3:0]  as;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  ms;
        logic [15:0] md;
        logic        cv;
        logic [3:0]  cs;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs [20];

    reg_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_sel     (alu_sel),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_sel     (mem_sel),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .wen         (wen),
        .selRd       (selRd),
        .rd          (rd),
        .claim_valid (claim_valid),
        .claim_sel   (claim_sel),
        .selRs       (selRs),
        .selRt       (selRt),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy)
    );

    always #5 clk = ~clk;

    // Regfile model fed by the write port
    always @(posedge clk) begin
        if (wen) tbRegs[selRd] <= rd;
    end

    function automatic logic [24:0] mkExp(input logic w, input logic [3:0] s, input logic [15:0] d,
                                          input logic ar, input logic mr, input logic rsb, input logic rtb);
        return {w, s, d, ar, mr, rsb, rtb};
    endfunction

    function automatic vec_t mkVec(input logic av, input logic [3:0] as, input logic [15:0] ad,
                                   input logic mv, input logic [3:0] ms, input logic [15:0] md,
                                   input logic cv, input logic [3:0] cs,
                                   input logic [3:0] rs, input logic [3:0] rt, input logic [24:0] e);
        vec_t v;
        v.av = av; v.as = as; v.ad = ad;
        v.mv = mv; v.ms = ms; v.md = md;
        v.cv = cv; v.cs = cs; v.rs = rs; v.rt = rt;
        v.exp = e;
        return v;
    endfunction

    function automatic logic [24:0] outs();
        return {wen, selRd, rd, alu_ready, mem_ready, rs_busy, rt_busy};
    endfunction

    task automatic applyStimulus(input vec_t v);
        alu_valid   = v.av; alu_sel = v.as; alu_data = v.ad;
        mem_valid   = v.mv; mem_sel = v.ms; mem_data = v.md;
        claim_valid = v.cv; claim_sel = v.cs;
        selRs       = v.rs; selRt = v.rt;
    endtask

    task automatic idleInputs();
        alu_valid = 1'b0; alu_sel = '0; alu_data = '0;
        mem_valid = 1'b0; mem_sel = '0; mem_data = '0;
        claim_valid = 1'b0; claim_sel = '0;
        selRs = '0; selRt = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        // Vectors: inputs drive a cycle, outputs checked before the closing edge
        vecs[0]  = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, mkExp(0,0,16'h0000,1,1,0,0));
        vecs[1]  = mkVec(0,0,16'h0000, 0,0,16'h0000, 1,3, 3,0, mkExp(0,0,16'h0000,1,1,0,0));
        vecs[2]  = mkVec(1,3,16'h00A5, 0,0,16'h0000, 0,0, 3,0, mkExp(0,0,16'h0000,1,1,1,0));
        vecs[3]  = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 3,0, mkExp(1,3,16'h00A5,1,1,1,0));
        vecs[4]  = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 3,0, mkExp(0,0,16'h0000,1,1,0,0));
        vecs[5]  = mkVec(0,0,16'h0000, 0,0,16'h0000, 1,9, 2,9, mkExp(0,0,16'h0000,1,1,0,0));
        vecs[6]  = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 2,9, mkExp(0,0,16'h0000,1,1,0,1));
        vecs[7]  = mkVec(1,1,16'h1111, 1,2,16'h2222, 0,0, 0,0, mkExp(0,0,16'h0000,1,1,0,0));
        vecs[8]  = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, mkExp(1,2,16'h2222,0,1,0,0));
        vecs[9]  = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, mkExp(1,1,16'h1111,1,1,0,0));
        vecs[10] = mkVec(1,4,16'h4444, 1,5,16'h5555, 0,0, 0,0, mkExp(0,0,16'h0000,1,1,0,0));
        vecs[11] = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, mkExp(1,4,16'h4444,1,0,0,0));
        vecs[12] = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, mkExp(1,5,16'h5555,1,1,0,0));
        vecs[13] = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, mkExp(0,0,16'h0000,1,1,0,0));
        vecs[14] = mkVec(1,5,16'h0055, 0,0,16'h0000, 1,5, 5,0, mkExp(0,0,16'h0000,1,1,0,0));
        vecs[15] = mkVec(0,0,16'h0000, 0,0,16'h0000, 1,5, 5,0, mkExp(1,5,16'h0055,1,1,1,0));
        vecs[16] = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 5,0, mkExp(0,0,16'h0000,1,1,1,0));
        vecs[17] = mkVec(1,5,16'h0ABC, 0,0,16'h0000, 0,0, 5,0, mkExp(0,0,16'h0000,1,1,1,0));
        vecs[18] = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 5,0, mkExp(1,5,16'h0ABC,1,1,1,0));
        vecs[19] = mkVec(0,0,16'h0000, 0,0,16'h0000, 0,0, 5,0, mkExp(0,0,16'h0000,1,1,0,0));

        idleInputs();
        rst = 1'b1;
        #1;
        checkOutput("reset_state", {7'd0, outs()}, {7'd0, mkExp(0,0,16'h0000,1,1,0,0)});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table: single ALU write, dual query, contention, claim/commit collision
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i), {7'd0, outs()}, {7'd0, vecs[i].exp});
            if (i == 4) checkOutput("regfile_r3", {16'd0, tbRegs[3]}, 32'h00A5);
        end

        // Streaming: one ALU result per cycle, each written the following cycle
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            idleInputs();
            if (i < 8) begin
                alu_valid = 1'b1;
                alu_sel   = 4'(i);
                alu_data  = 16'(i);
            end
            #1;
            if (i > 0) begin
                checkOutput($sformatf("stream%0d", i), {11'd0, wen, selRd, rd, alu_ready},
                            {11'd0, 1'b1, 4'(i - 1), 16'(i - 1), 1'b1});
            end
        end
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("stream_idle", {31'd0, wen}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            checkOutput($sformatf("regfile_r%0d", r), {16'd0, tbRegs[r]}, 32'(r));
        end

        // Mid-run reset with both slots held and a register claimed
        @(negedge clk);
        alu_valid = 1'b1; alu_sel = 4'hA; alu_data = 16'hAAAA;
        mem_valid = 1'b1; mem_sel = 4'hB; mem_data = 16'hBBBB;
        claim_valid = 1'b1; claim_sel = 4'h7;
        @(negedge clk);
        idleInputs();
        selRs = 4'h7;
        #1;
        checkOutput("pre_reset_busy", {30'd0, wen, rs_busy}, {30'd0, 1'b1, 1'b1});
        rst = 1'b1;
        #1;
        checkOutput("reset_midrun", {28'd0, wen, alu_ready, mem_ready, rs_busy}, {28'd0, 4'b0110});
        begin
            logic [15:0] anyBusy;
            anyBusy = '0;
            for (int r = 0; r < 16; r++) begin
                selRs = 4'(r);
                selRt = 4'(15 - r);
                #1;
                anyBusy[r] = rs_busy | rt_busy;
            end
            checkOutput("reset_busy_all", {16'd0, anyBusy}, 32'd0);
        end
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset_dropped", {29'd0, wen, alu_ready, mem_ready}, {29'd0, 3'b011});

        // First contention after reset must go to the memory side
        @(negedge clk);
        alu_valid = 1'b1; alu_sel = 4'hC; alu_data = 16'hCCCC;
        mem_valid = 1'b1; mem_sel = 4'hD; mem_data = 16'hDDDD;
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("post_reset_rr", {11'd0, wen, selRd, rd}, {11'd0, 1'b1, 4'hD, 16'hDDDD});
        @(negedge clk);
        #1;
        checkOutput("post_reset_rr2", {11'd0, wen, selRd, rd}, {11'd0, 1'b1, 4'hC, 16'hCCCC});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
